// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_if
// Brief    : Redirect request / fetch address bundle for the IF1 program counter
// Revision : 1.0
// ============================================================================
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            en;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            ret_valid;
  logic [XLEN-1:0] ret_target;
  logic            branch_valid;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] current_pc_if1;
  logic            pc_valid_if1;
  logic            fetch_fault_if1;
  logic [1:0]      fault_cause_if1;
  logic            flush_if1;

  modport master (
    output en, trap_valid, trap_target, ret_valid, ret_target,
           branch_valid, branch_target,
    input  current_pc_if1, pc_valid_if1, fetch_fault_if1,
           fault_cause_if1, flush_if1
  );

  modport slave (
    input  en, trap_valid, trap_target, ret_valid, ret_target,
           branch_valid, branch_target,
    output current_pc_if1, pc_valid_if1, fetch_fault_if1,
           fault_cause_if1, flush_if1
  );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : IF1 program counter with prioritised redirects, a one-entry
//            stall buffer and sticky fetch-fault detection
// Revision : 1.0
// ============================================================================
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [XLEN-1:0] IMEM_BASE    = 32'h8000_0000,
  parameter logic [XLEN-1:0] IMEM_SIZE    = 32'h0000_0C80,
  parameter int unsigned     INSTR_BYTES  = 4
) (
  input  wire logic  clk,
  input  wire logic  reset,
  pc_unit_if.slave   pc_if
);

  typedef enum logic [1:0] {
    PRIO_NONE   = 2'd0,
    PRIO_BRANCH = 2'd1,
    PRIO_RET    = 2'd2,
    PRIO_TRAP   = 2'd3
  } prio_t;

  localparam logic [XLEN-1:0] c_align_mask = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] c_step       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN:0]   c_win_lo     = {1'b0, IMEM_BASE};
  localparam logic [XLEN:0]   c_win_hi     = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

  // {out_of_range, misaligned}; window end is held in XLEN+1 bits so it cannot wrap
  function automatic logic [1:0] f_cause(input logic [XLEN-1:0] addr);
    logic [XLEN:0] ext;
    logic          mis;
    logic          oor;
    ext = {1'b0, addr};
    mis = (addr & c_align_mask) != '0;
    oor = (ext < c_win_lo) || (ext >= c_win_hi);
    return {oor, mis};
  endfunction

  localparam logic [1:0] c_reset_cause = f_cause(RESET_VECTOR);

  logic [XLEN-1:0] pc_q;
  logic [1:0]      cause_q;
  logic            flush_q;
  logic            pend_valid_q;
  prio_t           pend_prio_q;
  logic [XLEN-1:0] pend_target_q;

  prio_t           w_live_prio;
  logic [XLEN-1:0] w_live_target;
  logic            w_take_live;
  logic            w_sel_valid;
  logic [XLEN-1:0] w_sel_target;
  logic [XLEN-1:0] w_seq_pc;

  always_comb begin
    w_live_prio   = PRIO_NONE;
    w_live_target = '0;
    if (pc_if.trap_valid) begin
      w_live_prio   = PRIO_TRAP;
      w_live_target = pc_if.trap_target;
    end else if (pc_if.ret_valid) begin
      w_live_prio   = PRIO_RET;
      w_live_target = pc_if.ret_target;
    end else if (pc_if.branch_valid) begin
      w_live_prio   = PRIO_BRANCH;
      w_live_target = pc_if.branch_target;
    end
  end

  // Live request beats an equal-priority buffered one; the same test decides
  // both buffer replacement during a stall and the final pick when advancing.
  assign w_take_live  = (w_live_prio != PRIO_NONE) &&
                        (!pend_valid_q || (w_live_prio >= pend_prio_q));
  assign w_sel_valid  = w_take_live || pend_valid_q;
  assign w_sel_target = w_take_live ? w_live_target : pend_target_q;
  assign w_seq_pc     = pc_q + c_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      cause_q       <= c_reset_cause;
      flush_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_prio_q   <= PRIO_NONE;
      pend_target_q <= '0;
    end else if (pc_if.en) begin
      if (w_sel_valid) begin
        pc_q         <= w_sel_target;
        cause_q      <= f_cause(w_sel_target);
        flush_q      <= 1'b1;
        pend_valid_q <= 1'b0;
        pend_prio_q  <= PRIO_NONE;
      end else if (cause_q == 2'b00) begin
        pc_q    <= w_seq_pc;
        cause_q <= f_cause(w_seq_pc);
        flush_q <= 1'b0;
      end else begin
        flush_q <= 1'b0;
      end
    end else begin
      flush_q <= 1'b0;
      if (w_take_live) begin
        pend_valid_q  <= 1'b1;
        pend_prio_q   <= w_live_prio;
        pend_target_q <= w_live_target;
      end
    end
  end

  assign pc_if.current_pc_if1  = pc_q;
  assign pc_if.fault_cause_if1 = cause_q;
  assign pc_if.fetch_fault_if1 = |cause_q;
  assign pc_if.pc_valid_if1    = ~|cause_q;
  assign pc_if.flush_if1       = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed plus randomised check of pc_unit against a reference model
// Revision : 1.0
// ============================================================================
module tb_pc_unit;
  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h8000_0000;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0000_0C80;
  localparam int unsigned IB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_unit_if #(.XLEN(XLEN)) pc_bus ();

  pc_unit #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .IMEM_BASE(BASE),
    .IMEM_SIZE(SIZE), .INSTR_BYTES(IB)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .pc_if (pc_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [31:0] m_pc    = '0;
  logic [1:0]  m_cause = '0;
  logic        m_flush = 1'b0;
  bit          m_pv    = 1'b0;
  int          m_pp    = 0;
  logic [31:0] m_pt    = '0;

  function automatic logic [1:0] exp_cause(input logic [31:0] a);
    longint unsigned v;
    longint unsigned lo;
    longint unsigned hi;
    logic [1:0] c;
    v  = longint'(a);
    lo = longint'(BASE);
    hi = lo + longint'(SIZE);
    c  = 2'b00;
    if ((v % IB) != 0) c[0] = 1'b1;
    if (v < lo || v >= hi) c[1] = 1'b1;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e,
                            input logic tv, input logic [31:0] tt,
                            input logic rv, input logic [31:0] rt,
                            input logic bv, input logic [31:0] bt);
    int lp;
    logic [31:0] lt;
    int bp;
    logic [31:0] btg;
    lp = 0; lt = '0;
    if (tv)      begin lp = 3; lt = tt; end
    else if (rv) begin lp = 2; lt = rt; end
    else if (bv) begin lp = 1; lt = bt; end
    if (r) begin
      m_pc = RV; m_cause = exp_cause(RV); m_flush = 1'b0; m_pv = 1'b0; m_pp = 0;
    end else if (!e) begin
      m_flush = 1'b0;
      if (lp > 0 && (!m_pv || lp >= m_pp)) begin
        m_pv = 1'b1; m_pp = lp; m_pt = lt;
      end
    end else begin
      bp = 0; btg = '0;
      if (m_pv) begin bp = m_pp; btg = m_pt; end
      if (lp > 0 && lp >= bp) begin bp = lp; btg = lt; end
      if (bp > 0) begin
        m_pc = btg; m_cause = exp_cause(btg); m_flush = 1'b1; m_pv = 1'b0; m_pp = 0;
      end else if (m_cause == 2'b00) begin
        m_pc = m_pc + IB; m_cause = exp_cause(m_pc); m_flush = 1'b0;
      end else begin
        m_flush = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e,
                       input logic tv, input logic [31:0] tt,
                       input logic rv, input logic [31:0] rt,
                       input logic bv, input logic [31:0] bt);
    rst                  = r;
    pc_bus.en            = e;
    pc_bus.trap_valid    = tv;
    pc_bus.trap_target   = tt;
    pc_bus.ret_valid     = rv;
    pc_bus.ret_target    = rt;
    pc_bus.branch_valid  = bv;
    pc_bus.branch_target = bt;
    @(posedge clk);
    model_step(r, e, tv, tt, rv, rt, bv, bt);
    #1;
  endtask

  task automatic idle(input logic e);
    cycle(1'b0, e, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic br(input logic e, input logic [31:0] t);
    cycle(1'b0, e, 1'b0, '0, 1'b0, '0, 1'b1, t);
  endtask

  task automatic tr(input logic e, input logic [31:0] t);
    cycle(1'b0, e, 1'b1, t, 1'b0, '0, 1'b0, '0);
  endtask

  // Hand-computed expectations: pin both the DUT and the model
  task automatic pin(input string n, input logic [31:0] pc, input logic [1:0] cause, input logic fl);
    check({n, ".pc"},       pc_bus.current_pc_if1,          pc);
    check({n, ".model_pc"}, m_pc,                           pc);
    check({n, ".cause"},    32'(pc_bus.fault_cause_if1),    32'(cause));
    check({n, ".flush"},    32'(pc_bus.flush_if1),          32'(fl));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp.pc",    pc_bus.current_pc_if1,        m_pc);
      check("cmp.cause", 32'(pc_bus.fault_cause_if1),  32'(m_cause));
      check("cmp.fault", 32'(pc_bus.fetch_fault_if1),  32'(m_cause != 2'b00));
      check("cmp.valid", 32'(pc_bus.pc_valid_if1),     32'(m_cause == 2'b00));
      check("cmp.flush", 32'(pc_bus.flush_if1),        32'(m_flush));
    end
  end

  function automatic logic [31:0] rand_target();
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return 32'($urandom);
    if (sel < 3)  return BASE + 32'($urandom_range(0, 32'hD00));
    return BASE + (32'($urandom_range(0, 32'hCC0)) & 32'hFFFF_FFFC);
  endfunction

  initial begin
    idle(1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    chk_en = 1'b1;
    pin("reset", 32'h8000_0000, 2'b00, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      idle(1'b1);
      pin("seq", 32'h8000_0000 + 32'(4 * i), 2'b00, 1'b0);
    end

    cycle(1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0300);
    pin("prio", 32'h8000_0100, 2'b00, 1'b1);
    idle(1'b1);
    pin("prio_next", 32'h8000_0104, 2'b00, 1'b0);

    br(1'b0, 32'h8000_0040);
    pin("stall1", 32'h8000_0104, 2'b00, 1'b0);
    tr(1'b0, 32'h8000_0080);
    pin("stall2", 32'h8000_0104, 2'b00, 1'b0);
    idle(1'b0);
    pin("stall3", 32'h8000_0104, 2'b00, 1'b0);
    idle(1'b1);
    pin("pend_apply", 32'h8000_0080, 2'b00, 1'b1);
    idle(1'b1);
    pin("pend_empty", 32'h8000_0084, 2'b00, 1'b0);

    br(1'b1, 32'h8000_0042);
    pin("misalign", 32'h8000_0042, 2'b01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      pin("mis_hold", 32'h8000_0042, 2'b01, 1'b0);
    end
    br(1'b1, 32'h8000_0010);
    pin("mis_recover", 32'h8000_0010, 2'b00, 1'b1);

    br(1'b1, 32'h8000_0C74);
    idle(1'b1);
    idle(1'b1);
    pin("win_last", 32'h8000_0C7C, 2'b00, 1'b0);
    idle(1'b1);
    pin("win_end", 32'h8000_0C80, 2'b10, 1'b0);
    idle(1'b1);
    pin("win_hold", 32'h8000_0C80, 2'b10, 1'b0);
    tr(1'b1, 32'h8000_0000);
    pin("win_recover", 32'h8000_0000, 2'b00, 1'b1);

    br(1'b0, 32'h8000_0040);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    pin("rst_pend", 32'h8000_0000, 2'b00, 1'b0);
    idle(1'b1);
    pin("rst_pend_gone", 32'h8000_0004, 2'b00, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 70,
            $urandom_range(0, 9) < 1, rand_target(),
            $urandom_range(0, 9) < 1, rand_target(),
            $urandom_range(0, 9) < 2, rand_target());
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program counter for the core datapath with a configurable reset vector and redirect sources. Trap, return and branch redirects are resolved by fixed priority. A redirect that arrives during a stall is held in a one-entry buffer, so it is never lost. Fetch addresses that are misaligned or outside the instruction-memory window are flagged, and the PC is held until a redirect arrives. Sits in IF1 and drives the instruction-memory address and the IF1/IF2 pipeline register.

## Interface
Parameters:
- XLEN, 32, PC width in bits
- RESET_VECTOR, 32'h8000_0000, PC value after reset
- IMEM_BASE, 32'h8000_0000, lowest legal fetch address
- IMEM_SIZE, 32'h0000_0C80, legal window size in bytes (byte count, enforced)
- INSTR_BYTES, 4, sequential increment; power of two; also the alignment requirement

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  advance enable; 0 = stall
- trap_valid  input  1  trap redirect request
- trap_target  input  XLEN  trap vector
- ret_valid  input  1  return (mret) redirect request
- ret_target  input  XLEN  return address
- branch_valid  input  1  branch/jump redirect request
- branch_target  input  XLEN  branch target
- current_pc_if1  output  XLEN  current fetch address
- pc_valid_if1  output  1  current_pc_if1 is a legal fetch
- fetch_fault_if1  output  1  current PC is faulted
- fault_cause_if1  output  2  01 = misaligned, 10 = out of range, 11 = both, 00 = none
- flush_if1  output  1  one-cycle pulse: PC was just loaded from a redirect

## Operation
- Redirect priority, highest first: trap, ret, branch. Only the selected target is used. Lower requests in the same cycle are discarded.
- **Pending buffer** (pend_valid, pend_prio, pend_target):
  - Written only while en=0 and some live redirect is valid.
  - The live winner replaces the buffer entry if its priority is greater than or equal to pend_prio. Otherwise the buffer is unchanged.
- **Next-PC selection when en=1**:
  - Candidates are the live winner and the pending entry. The higher priority wins. On equal priority the live request wins.
  - If any candidate exists, next = winning target, flush_if1 = 1 next cycle, and the pending entry is cleared.
  - Otherwise, if not faulted, next = current + INSTR_BYTES, with modulo 2^XLEN wrap.
  - Otherwise (faulted, no redirect), the PC is held.
- **en=0**: PC, valid and fault outputs hold. flush_if1 = 0. Only the pending buffer can change.
- **Fault check** on every loaded next value, redirect or sequential:
  - misaligned = next[log2(INSTR_BYTES)-1:0] != 0
  - out of range = next < IMEM_BASE, or next ≥ IMEM_BASE+IMEM_SIZE. The sum is computed in XLEN+1 bits, so there is no overflow.
  - On a fault, the PC still loads the value, fetch_fault_if1 = 1, the cause is set, and pc_valid_if1 = 0.
- The fault is sticky. Sequential increments are suppressed until a redirect loads a new PC; that load is re-checked.
- pc_valid_if1 = ~fetch_fault_if1 at all times.

## Timing
- All outputs are registered. A redirect or advance presented in cycle N is visible on the outputs in cycle N+1.
- A pending redirect takes effect in the cycle after the first en=1 cycle.
- **Reset** (synchronous; reset has priority over all other inputs):
  - current_pc_if1 = RESET_VECTOR, pc_valid_if1 = 1, fetch_fault_if1 = 0, fault_cause_if1 = 00, flush_if1 = 0.
  - The pending buffer is cleared.
- Reset asserted mid-stall with a pending redirect: the redirect is discarded and the PC returns to RESET_VECTOR.
- flush_if1 is high for exactly one cycle per applied redirect, including a redirect to a faulting target.
- With RESET_VECTOR outside the window, the first cycle after reset must already show the fault. Reset therefore applies the same fault check to RESET_VECTOR.

## Test plan
- Reset, then en=1 for 4 cycles: PC = 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C, 0x8000_0010. valid=1 and flush=0 throughout.
- Same cycle with en=1: trap_valid (0x8000_0100), ret_valid (0x8000_0200) and branch_valid (0x8000_0300). Next PC = 0x8000_0100, flush=1 for one cycle, then PC increments to 0x8000_0104.
- en=0 for 3 cycles; branch to 0x8000_0040 in the first, trap to 0x8000_0080 in the second; then en=1 with no live request. PC holds during the stall, then PC = 0x8000_0080 with a single flush pulse. The buffer is empty afterwards.
- en=1, branch to 0x8000_0042: PC = 0x8000_0042, cause=01, valid=0. PC then holds for 5 cycles. A branch to 0x8000_0010 clears the fault.
- Sequential fetch reaching 0x8000_0C7C: the next PC is 0x8000_0C80 with cause=10 and valid=0, and it holds. A trap to 0x8000_0000 recovers.
- Reset asserted while pend_valid=1 with en=0: PC = 0x8000_0000 next cycle. A later en=1 produces no flush.
